// File: rtl/cpu_pkg.sv
// Shared integer-pipeline constants: default register width, register count and the
// register-index type used by decode, the register file and the scoreboard.
package cpu_pkg;

    localparam int XLEN  = 64;
    localparam int NREGS = 32;
    localparam int AW    = $clog2(NREGS);

    typedef logic [AW-1:0] reg_idx_t;

endpackage

// File: rtl/reg_scoreboard.sv
// In-flight writer scoreboard: per-register outstanding-write counters, operand
// busy flags, issue gating, idle and sticky underflow error.
module reg_scoreboard #(
    parameter int NREGS        = cpu_pkg::NREGS,
    parameter int NRD          = 2,
    parameter int MAX_INFLIGHT = 3,
    localparam int AW          = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NRD*AW-1:0] rd_addr,
    output logic [NRD-1:0]    rd_busy,
    input  logic              iss_valid,
    input  logic [NRD-1:0]    iss_use,
    input  logic              iss_wen,
    input  logic [AW-1:0]     iss_rd,
    output logic              iss_ready,
    input  logic              wb_valid,
    input  logic [AW-1:0]     wb_rd,
    input  logic              cancel_valid,
    input  logic [AW-1:0]     cancel_rd,
    output logic              idle,
    output logic              err
);

    localparam int CW = $clog2(MAX_INFLIGHT + 1);

    logic [CW-1:0] cnt     [NREGS];
    logic [CW-1:0] cnt_nxt [NREGS];
    logic          err_q;
    logic          err_set;
    logic          iss_acc;
    logic          hazard;
    logic          room;
    logic [AW-1:0] a_k;
    int            dec_n;
    int            delta;
    int            sum;

    // A source with exactly one writer left is free when that writer retires now.
    always_comb begin
        rd_busy = '0;
        a_k     = '0;
        for (int k = 0; k < NRD; k++) begin
            a_k = rd_addr[k*AW +: AW];
            if (a_k != '0) begin
                if (cnt[a_k] > CW'(1))
                    rd_busy[k] = 1'b1;
                else if (cnt[a_k] == CW'(1) && !(wb_valid && wb_rd == a_k))
                    rd_busy[k] = 1'b1;
            end
        end
    end

    always_comb begin
        hazard = |(iss_use & rd_busy);
        dec_n  = 0;
        if (wb_valid && wb_rd == iss_rd)
            dec_n = dec_n + 1;
        if (cancel_valid && cancel_rd == iss_rd)
            dec_n = dec_n + 1;
        room      = (int'(cnt[iss_rd]) - dec_n) < MAX_INFLIGHT;
        iss_ready = !hazard && (!iss_wen || iss_rd == '0 || room);
    end

    assign iss_acc = iss_valid && iss_ready;

    // Same-edge events on one register sum; a negative result clamps and flags err.
    always_comb begin
        err_set    = 1'b0;
        delta      = 0;
        sum        = 0;
        cnt_nxt[0] = '0;
        for (int r = 1; r < NREGS; r++) begin
            delta = 0;
            if (iss_acc && iss_wen && iss_rd == AW'(r))
                delta = delta + 1;
            if (wb_valid && wb_rd == AW'(r))
                delta = delta - 1;
            if (cancel_valid && cancel_rd == AW'(r))
                delta = delta - 1;
            sum = int'(cnt[r]) + delta;
            if (sum < 0) begin
                cnt_nxt[r] = '0;
                err_set    = 1'b1;
            end else begin
                cnt_nxt[r] = CW'(sum);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NREGS; r++)
                cnt[r] <= '0;
            err_q <= 1'b0;
        end else begin
            for (int r = 0; r < NREGS; r++)
                cnt[r] <= cnt_nxt[r];
            if (err_set)
                err_q <= 1'b1;
        end
    end

    always_comb begin
        idle = 1'b1;
        for (int r = 0; r < NREGS; r++)
            if (cnt[r] != '0)
                idle = 1'b0;
    end

    assign err = err_q;

endmodule

// File: rtl/regfile_sb.sv
// Integer register file with write-back bypass on every read port; outstanding-writer
// tracking and issue gating live in reg_scoreboard.
module regfile_sb #(
    parameter int XLEN         = cpu_pkg::XLEN,
    parameter int NREGS        = cpu_pkg::NREGS,
    parameter int NRD          = 2,
    parameter int MAX_INFLIGHT = 3,
    parameter int INIT_IDX     = 0,
    localparam int AW          = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic                iss_valid,
    input  logic [NRD-1:0]      iss_use,
    input  logic                iss_wen,
    input  logic [AW-1:0]       iss_rd,
    output logic                iss_ready,
    input  logic                wb_valid,
    input  logic [AW-1:0]       wb_rd,
    input  logic [XLEN-1:0]     wb_data,
    input  logic                cancel_valid,
    input  logic [AW-1:0]       cancel_rd,
    output logic                idle,
    output logic                err
);

    logic [XLEN-1:0] regs [NREGS];
    logic [AW-1:0]   a_k;

    // A write-back coinciding with reset is dropped along with the reservations.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++)
                regs[i] <= (INIT_IDX != 0) ? XLEN'(i) : '0;
        end else if (wb_valid && wb_rd != '0) begin
            regs[wb_rd] <= wb_data;
        end
    end

    always_comb begin
        rd_data = '0;
        a_k     = '0;
        for (int k = 0; k < NRD; k++) begin
            a_k = rd_addr[k*AW +: AW];
            if (a_k == '0)
                rd_data[k*XLEN +: XLEN] = '0;
            else if (wb_valid && wb_rd == a_k)
                rd_data[k*XLEN +: XLEN] = wb_data;
            else
                rd_data[k*XLEN +: XLEN] = regs[a_k];
        end
    end

    reg_scoreboard #(
        .NREGS        (NREGS),
        .NRD          (NRD),
        .MAX_INFLIGHT (MAX_INFLIGHT)
    ) u_scoreboard (
        .clk          (clk),
        .reset        (reset),
        .rd_addr      (rd_addr),
        .rd_busy      (rd_busy),
        .iss_valid    (iss_valid),
        .iss_use      (iss_use),
        .iss_wen      (iss_wen),
        .iss_rd       (iss_rd),
        .iss_ready    (iss_ready),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .cancel_valid (cancel_valid),
        .cancel_rd    (cancel_rd),
        .idle         (idle),
        .err          (err)
    );

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed scenarios followed by random traffic,
// all compared against a counting reference model of the register file.
module tb_regfile_sb;

    localparam int XLEN  = 64;
    localparam int NREGS = 32;
    localparam int NRD   = 2;
    localparam int MAXI  = 3;
    localparam int AW    = 5;

    logic                clk = 1'b0;
    logic                reset;
    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic                iss_valid;
    logic [NRD-1:0]      iss_use;
    logic                iss_wen;
    logic [AW-1:0]       iss_rd;
    logic                iss_ready;
    logic                wb_valid;
    logic [AW-1:0]       wb_rd;
    logic [XLEN-1:0]     wb_data;
    logic                cancel_valid;
    logic [AW-1:0]       cancel_rd;
    logic                idle;
    logic                err;

    always #5 clk = ~clk;

    regfile_sb #(
        .XLEN         (XLEN),
        .NREGS        (NREGS),
        .NRD          (NRD),
        .MAX_INFLIGHT (MAXI),
        .INIT_IDX     (1)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .rd_busy      (rd_busy),
        .iss_valid    (iss_valid),
        .iss_use      (iss_use),
        .iss_wen      (iss_wen),
        .iss_rd       (iss_rd),
        .iss_ready    (iss_ready),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .cancel_valid (cancel_valid),
        .cancel_rd    (cancel_rd),
        .idle         (idle),
        .err          (err)
    );

    int              tests = 0;
    int              fails = 0;
    int              mcnt [NREGS];
    logic [XLEN-1:0] mreg [NREGS];
    bit              merr;
    bit              exp_ready_q;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < NREGS; r++) begin
            mcnt[r] = 0;
            mreg[r] = XLEN'(r);
        end
        merr = 1'b0;
    endtask

    function automatic int wb_hits(input int a);
        return (wb_valid && int'(wb_rd) == a) ? 1 : 0;
    endfunction

    // Busy means writers still outstanding after this cycle's write-back retires.
    function automatic bit model_busy(input int a);
        if (a == 0)
            return 1'b0;
        return (mcnt[a] - wb_hits(a)) > 0;
    endfunction

    function automatic bit model_ready();
        int left;
        for (int k = 0; k < NRD; k++)
            if (iss_use[k] && model_busy(int'(rd_addr[k*AW +: AW])))
                return 1'b0;
        if (!iss_wen || iss_rd == 0)
            return 1'b1;
        left = mcnt[iss_rd] - wb_hits(int'(iss_rd));
        if (cancel_valid && cancel_rd == iss_rd)
            left--;
        return left < MAXI;
    endfunction

    task automatic quiet();
        reset        = 1'b0;
        rd_addr      = '0;
        iss_valid    = 1'b0;
        iss_use      = '0;
        iss_wen      = 1'b0;
        iss_rd       = '0;
        wb_valid     = 1'b0;
        wb_rd        = '0;
        wb_data      = '0;
        cancel_valid = 1'b0;
        cancel_rd    = '0;
    endtask

    task automatic set_rd(input int k, input int a);
        rd_addr[k*AW +: AW] = AW'(a);
    endtask

    task automatic issue(input int r);
        iss_valid = 1'b1;
        iss_wen   = 1'b1;
        iss_rd    = AW'(r);
    endtask

    task automatic settle_check(input string ph);
        int              a;
        logic [XLEN-1:0] exp_d;
        #3;
        for (int k = 0; k < NRD; k++) begin
            a = int'(rd_addr[k*AW +: AW]);
            if (a == 0)
                exp_d = '0;
            else if (wb_hits(a) != 0)
                exp_d = wb_data;
            else
                exp_d = mreg[a];
            check($sformatf("%s_data%0d", ph, k), rd_data[k*XLEN +: XLEN], exp_d);
            check($sformatf("%s_busy%0d", ph, k), 64'(rd_busy[k]), 64'(model_busy(a)));
        end
        exp_ready_q = model_ready();
        check({ph, "_ready"}, 64'(iss_ready), 64'(exp_ready_q));
        begin
            bit all_zero = 1'b1;
            for (int r = 0; r < NREGS; r++)
                if (mcnt[r] != 0)
                    all_zero = 1'b0;
            check({ph, "_idle"}, 64'(idle), 64'(all_zero));
        end
        check({ph, "_err"}, 64'(err), 64'(merr));
    endtask

    task automatic clk_edge();
        if (reset) begin
            model_reset();
        end else begin
            if (iss_valid && exp_ready_q && iss_wen && iss_rd != 0)
                mcnt[iss_rd]++;
            if (wb_valid && wb_rd != 0) begin
                mcnt[wb_rd]--;
                mreg[wb_rd] = wb_data;
            end
            if (cancel_valid && cancel_rd != 0)
                mcnt[cancel_rd]--;
            for (int r = 0; r < NREGS; r++)
                if (mcnt[r] < 0) begin
                    mcnt[r] = 0;
                    merr    = 1'b1;
                end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic step(input string ph);
        settle_check(ph);
        clk_edge();
    endtask

    initial begin
        int pend [$];
        quiet();
        reset = 1'b1;
        @(posedge clk);
        #1;
        model_reset();

        // reset values and INIT_IDX preload
        quiet(); set_rd(0, 5); set_rd(1, 31);
        settle_check("init");
        check("init_x5", rd_data[63:0], 64'd5);
        check("init_x31", rd_data[127:64], 64'd31);
        clk_edge();
        quiet();
        settle_check("init_x0");
        check("init_x0_idle", 64'(idle), 64'd1);
        clk_edge();

        // RAW stall released by the producing write-back
        quiet(); issue(7); step("raw_iss");
        quiet(); set_rd(0, 7); iss_valid = 1'b1; iss_use = 2'b01;
        settle_check("raw_stall");
        check("raw_stall_ready", 64'(iss_ready), 64'd0);
        clk_edge();
        wb_valid = 1'b1; wb_rd = 5'd7; wb_data = 64'hABCD;
        settle_check("raw_wb");
        check("raw_wb_bypass", rd_data[63:0], 64'hABCD);
        check("raw_wb_ready", 64'(iss_ready), 64'd1);
        clk_edge();
        quiet(); set_rd(0, 7);
        settle_check("raw_done");
        check("raw_done_idle", 64'(idle), 64'd1);
        check("raw_done_array", rd_data[63:0], 64'hABCD);
        clk_edge();

        // saturation of one destination
        for (int i = 0; i < 3; i++) begin
            quiet(); issue(3); step("sat_fill");
        end
        quiet(); issue(3);
        settle_check("sat_full");
        check("sat_full_ready", 64'(iss_ready), 64'd0);
        clk_edge();
        wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 64'h33;
        settle_check("sat_wb");
        check("sat_wb_ready", 64'(iss_ready), 64'd1);
        clk_edge();
        quiet(); issue(3);
        settle_check("sat_still3");
        check("sat_still3_ready", 64'(iss_ready), 64'd0);
        clk_edge();
        for (int i = 0; i < 3; i++) begin
            quiet(); wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 64'(i); step("sat_drain");
        end

        // write-back to x0 is ignored
        quiet(); wb_valid = 1'b1; wb_rd = '0; wb_data = 64'hFFFF;
        settle_check("x0_wb");
        check("x0_wb_data", rd_data[63:0], 64'd0);
        clk_edge();
        quiet();
        settle_check("x0_after");
        check("x0_after_err", 64'(err), 64'd0);
        clk_edge();

        // cancel, then cancel underflow
        quiet(); issue(9); step("cxl_iss");
        quiet(); cancel_valid = 1'b1; cancel_rd = 5'd9; step("cxl_ok");
        quiet();
        settle_check("cxl_clean");
        check("cxl_clean_err", 64'(err), 64'd0);
        clk_edge();
        quiet(); cancel_valid = 1'b1; cancel_rd = 5'd9; step("cxl_under");
        quiet();
        settle_check("cxl_err");
        check("cxl_err_set", 64'(err), 64'd1);
        clk_edge();
        settle_check("cxl_sticky");
        check("cxl_sticky_err", 64'(err), 64'd1);
        clk_edge();

        // reset mid-operation drops reservations and a coincident write-back
        quiet(); issue(4); step("rst_iss4");
        quiet(); issue(5); step("rst_iss5");
        quiet(); reset = 1'b1; wb_valid = 1'b1; wb_rd = 5'd10; wb_data = 64'h1234;
        step("rst_edge");
        quiet(); set_rd(0, 10); set_rd(1, 7);
        settle_check("rst_after");
        check("rst_after_idle", 64'(idle), 64'd1);
        check("rst_after_err", 64'(err), 64'd0);
        check("rst_after_x10", rd_data[63:0], 64'd10);
        check("rst_after_x7", rd_data[127:64], 64'd7);
        clk_edge();

        // random traffic on a small register window to provoke hazards
        for (int n = 0; n < 2000; n++) begin
            quiet();
            set_rd(0, $urandom_range(0, 7));
            set_rd(1, $urandom_range(0, 7));
            iss_use = NRD'($urandom_range(0, 3));
            if ($urandom_range(0, 9) < 7) begin
                iss_valid = 1'b1;
                iss_wen   = $urandom_range(0, 3) != 0;
                iss_rd    = AW'($urandom_range(0, 7));
            end
            pend.delete();
            for (int r = 1; r < NREGS; r++)
                if (mcnt[r] > 0)
                    pend.push_back(r);
            if (pend.size() > 0 && $urandom_range(0, 9) < 4) begin
                wb_valid = 1'b1;
                wb_rd    = AW'(pend[$urandom_range(0, pend.size() - 1)]);
                wb_data  = {$urandom, $urandom};
            end else if ($urandom_range(0, 49) == 0) begin
                wb_valid = 1'b1;
                wb_rd    = AW'($urandom_range(0, 7));
                wb_data  = {$urandom, $urandom};
            end
            if (pend.size() > 0 && $urandom_range(0, 9) == 0) begin
                cancel_valid = 1'b1;
                cancel_rd    = AW'(pend[$urandom_range(0, pend.size() - 1)]);
            end else if ($urandom_range(0, 99) == 0) begin
                cancel_valid = 1'b1;
                cancel_rd    = AW'($urandom_range(0, 7));
            end
            if ($urandom_range(0, 299) == 0)
                reset = 1'b1;
            step("rnd");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
